pc_sequencer: RTL

Parametrised program-counter sequencer for the MIPS datapath. It holds the architectural PC and selects the next PC from sequential, branch, jump, jump-register and exception sources. It also adds stall, a configurable reset/exception vector, misaligned-target detection, and a return-address stack (RAS) that predicts `jr $ra` targets. It sits at the head of instruction fetch, feeding the instruction-memory address and receiving redirect requests from decode/control.

---
 rtl/pc_pkg.sv | 17 +
 rtl/return_address_stack.sv | 54 +++++
 rtl/pc_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer: default vectors
// and the next-PC source encoding.
package pc_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXC_VECTOR   = 32'h8000_0180;

  typedef enum logic [2:0] {
    SEL_EXC,
    SEL_HOLD,
    SEL_REG,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } next_sel_e;

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack: push/pop/replace on the top entry,
// overwriting the oldest entry when pushed while full.
module return_address_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_inc;
  logic             do_pop;

  assign ptr_inc = ptr + PTR_W'(1);
  assign top     = mem[ptr];
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr_inc;
      if (count != CNT_W'(DEPTH))
        count <= count + CNT_W'(1);
    end else if (do_pop) begin
      ptr   <= ptr - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; a simultaneous pop+push rewrites the current top.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (push && do_pop)
        mem[ptr] <= data;
      else if (push)
        mem[ptr_inc] <= data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register and next-PC selection for instruction fetch,
// with exception vectoring, misaligned-target trapping and a return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned        WIDTH        = 32,
  parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
  parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(DEFAULT_EXC_VECTOR),
  parameter int unsigned        RAS_DEPTH    = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         branch_taken,
  input  logic [15:0]                  branch_offset,
  input  logic                         jump,
  input  logic [25:0]                  jump_index,
  input  logic                         jump_reg,
  input  logic                         is_ret,
  input  logic [WIDTH-1:0]             reg_target,
  input  logic                         call,
  input  logic                         exception,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus4,
  output logic [WIDTH-1:0]             epc,
  output logic                         addr_error,
  output logic [$clog2(RAS_DEPTH):0]   ras_count
);

  next_sel_e        sel;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] reg_tgt;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] next_pc;
  logic             ras_hit;
  logic             misaligned;
  logic             ras_en;
  logic             ras_push;
  logic             ras_pop;

  assign pc_plus4   = pc + WIDTH'(4);
  assign ras_hit    = is_ret && (ras_count != '0);
  assign reg_tgt    = ras_hit ? ras_top : reg_target;
  assign jump_tgt   = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
  assign branch_tgt = pc_plus4 + {{(WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (exception)         sel = SEL_EXC;
    else if (stall)        sel = SEL_HOLD;
    else if (jump_reg)     sel = SEL_REG;
    else if (jump)         sel = SEL_JUMP;
    else if (branch_taken) sel = SEL_BRANCH;
  end

  assign misaligned = (sel == SEL_REG) && (reg_tgt[1:0] != 2'b00);

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SEL_EXC:    next_pc = EXC_VECTOR;
      SEL_HOLD:   next_pc = pc;
      SEL_REG:    next_pc = misaligned ? EXC_VECTOR : reg_tgt;
      SEL_JUMP:   next_pc = jump_tgt;
      SEL_BRANCH: next_pc = branch_tgt;
      default:    next_pc = pc_plus4;
    endcase
  end

  // RAS moves only on an edge that actually redirects without trapping.
  assign ras_en   = (sel != SEL_EXC) && (sel != SEL_HOLD) && !misaligned;
  assign ras_push = ras_en && call;
  assign ras_pop  = ras_en && jump_reg && ras_hit;

  return_address_stack #(
    .WIDTH (WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .data  (pc_plus4),
    .top   (ras_top),
    .count (ras_count)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      addr_error <= 1'b0;
    end else begin
      pc         <= next_pc;
      addr_error <= misaligned;
      if ((sel == SEL_EXC) || misaligned)
        epc <= pc;
    end
  end

endmodule
